dbnc_sync: RTL

//   Conditions a raw asynchronous level (push-button, DIP switch, external strobe) into a clean synchronous level.
//   Two-stage job: N-flop synchronizer, then a counter-based debounce FSM.

---
 rtl/dbnc_sync.sv | 124 ++++++++++++
 1 files changed

// File: rtl/dbnc_sync.sv
// dbnc_sync: SYNC_STAGES-flop synchronizer followed by a counter-based debounce FSM.
// Define DBNC_EDGE_EN to build registered o_rise/o_fall strobes; otherwise both are tied low.
module dbnc_sync #(
   parameter int SYNC_STAGES = 2,
   parameter int DB_CYCLES   = 1000000,
   parameter int CNT_W       = 20
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_async,
   output logic o_level,
   output logic o_busy,
   output logic o_rise,
   output logic o_fall
);

   typedef enum logic [1:0] {
      STABLE_LO = 2'b00,
      WAIT_HI   = 2'b01,
      STABLE_HI = 2'b10,
      WAIT_LO   = 2'b11
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s;
   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   level_q, level_d;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], i_async};
      end
   end

   assign s = sync_q[SYNC_STAGES-1];

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= STABLE_LO;
         cnt_q   <= '0;
         level_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
      end
   end

   // Any sample agreeing with the current level aborts qualification and clears the count.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      level_d = level_q;
      case (state_q)
         STABLE_LO: begin
            cnt_d = '0;
            if (s) state_d = WAIT_HI;
         end
         WAIT_HI: begin
            if (!s) begin
               state_d = STABLE_LO;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = STABLE_HI;
               cnt_d   = '0;
               level_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         STABLE_HI: begin
            cnt_d = '0;
            if (!s) state_d = WAIT_LO;
         end
         WAIT_LO: begin
            if (s) begin
               state_d = STABLE_HI;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = STABLE_LO;
               cnt_d   = '0;
               level_d = 1'b0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = STABLE_LO;
            cnt_d   = '0;
            level_d = 1'b0;
         end
      endcase
   end

   assign o_level = level_q;
   assign o_busy  = (state_q == WAIT_HI) || (state_q == WAIT_LO);

`ifdef DBNC_EDGE_EN
   logic rise_q, fall_q;

   // Strobes are registered alongside level_q so they coincide with the first cycle of the new level.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         rise_q <= level_d & ~level_q;
         fall_q <= ~level_d & level_q;
      end
   end

   assign o_rise = rise_q;
   assign o_fall = fall_q;
`else
   assign o_rise = 1'b0;
   assign o_fall = 1'b0;
`endif

endmodule
